// File: rtl/cdr_ctrl_pkg.sv
// Shared types and default gain settings for the CDR loop-filter controller.
package cdr_ctrl_pkg;

    localparam int GAIN_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACQ   = 3'd2,
        ST_TRACK = 3'd3,
        ST_LOCK  = 3'd4
    } cdr_state_e;

    localparam logic [GAIN_W-1:0] DEF_FRUG_ACQ = 8'd8;
    localparam logic [GAIN_W-1:0] DEF_PHUG_ACQ = 8'd16;
    localparam logic [GAIN_W-1:0] DEF_FRUG_TRK = 8'd2;
    localparam logic [GAIN_W-1:0] DEF_PHUG_TRK = 8'd4;

    // States in which the phase-detector stream is being observed.
    function automatic logic in_window(input cdr_state_e s);
        return (s == ST_ACQ) || (s == ST_TRACK) || (s == ST_LOCK);
    endfunction

endpackage

// File: rtl/cdr_win_monitor.sv
// Fixed-length window observer of the Up/Dn stream; flags window end and
// classifies the closing window's net count as quiet and/or loud.
module cdr_win_monitor #(
    parameter int WIN_LEN    = 256,
    parameter int LOCK_THR   = 8,
    parameter int UNLOCK_THR = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_clr,
    input  logic i_up,
    input  logic i_dn,
    output logic o_win_end,
    output logic o_quiet,
    output logic o_loud
);

    localparam int CW = $clog2(WIN_LEN);
    localparam int NW = CW + 2;
    localparam logic [NW-1:0] LOCK_T   = NW'(LOCK_THR);
    localparam logic [NW-1:0] UNLOCK_T = NW'(UNLOCK_THR);

    logic [CW-1:0]        r_cnt;
    logic signed [NW-1:0] r_net;
    logic signed [NW-1:0] w_step;
    logic signed [NW-1:0] w_net_nxt;
    logic [NW-1:0]        w_mag;

    always_comb begin
        w_step = '0;
        if (i_up && !i_dn) begin
            w_step = NW'(1);
        end else if (i_dn && !i_up) begin
            w_step = '1;
        end
    end

    // Classification uses the net including the current cycle's pulse.
    assign w_net_nxt = r_net + w_step;
    assign w_mag     = w_net_nxt[NW-1] ? -w_net_nxt : w_net_nxt;
    assign o_win_end = i_run && (r_cnt == CW'(WIN_LEN - 1));
    assign o_quiet   = (w_mag <= LOCK_T);
    assign o_loud    = (w_mag > UNLOCK_T);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_net <= '0;
        end else if (i_clr || o_win_end) begin
            r_cnt <= '0;
            r_net <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
            r_net <= w_net_nxt;
        end
    end

endmodule

// File: rtl/cdr_loop_ctrl.sv
// Acquisition/tracking sequencer for the CDR loop filter: drives gains,
// integrator clear and lock status from windowed phase-detector activity.
module cdr_loop_ctrl
    import cdr_ctrl_pkg::*;
#(
    parameter int WIN_LEN    = 256,
    parameter int LOCK_THR   = 8,
    parameter int UNLOCK_THR = 32,
    parameter int ACQ_WINS   = 4,
    parameter int LOCK_WINS  = 8,
    parameter int HOLD_CYC   = 16,
    parameter logic [GAIN_W-1:0] FRUG_ACQ = DEF_FRUG_ACQ,
    parameter logic [GAIN_W-1:0] PHUG_ACQ = DEF_PHUG_ACQ,
    parameter logic [GAIN_W-1:0] FRUG_TRK = DEF_FRUG_TRK,
    parameter logic [GAIN_W-1:0] PHUG_TRK = DEF_PHUG_TRK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              dn,
    output logic [GAIN_W-1:0] frug,
    output logic [GAIN_W-1:0] phug,
    output logic              lf_clr,
    output logic              locked,
    output logic              lock_lost,
    output logic [2:0]        state
);

    localparam int MAXW = (ACQ_WINS > LOCK_WINS) ? ACQ_WINS : LOCK_WINS;
    localparam int QW   = $clog2(MAXW + 1);
    localparam int HW   = $clog2(HOLD_CYC + 1);

    cdr_state_e        r_state;
    cdr_state_e        w_next;
    logic [QW-1:0]     r_qcnt;
    logic [QW-1:0]     w_qcnt_inc;
    logic [HW-1:0]     r_hold;
    logic [GAIN_W-1:0] r_frug;
    logic [GAIN_W-1:0] r_phug;
    logic              r_lf_clr;
    logic              r_locked;
    logic              r_lock_lost;
    logic              w_win_end;
    logic              w_quiet;
    logic              w_loud;
    logic              w_chg;
    logic              w_win_clr;
    logic              w_trk_gain;

    cdr_win_monitor #(
        .WIN_LEN    (WIN_LEN),
        .LOCK_THR   (LOCK_THR),
        .UNLOCK_THR (UNLOCK_THR)
    ) u_win (
        .clk       (clk),
        .rst       (rst),
        .i_run     (in_window(r_state)),
        .i_clr     (w_win_clr),
        .i_up      (up),
        .i_dn      (dn),
        .o_win_end (w_win_end),
        .o_quiet   (w_quiet),
        .o_loud    (w_loud)
    );

    assign w_qcnt_inc = r_qcnt + QW'(1);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (en) w_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (r_hold == HW'(HOLD_CYC - 1)) w_next = ST_ACQ;
            end
            ST_ACQ: begin
                if (w_win_end && w_quiet && (w_qcnt_inc == QW'(ACQ_WINS))) w_next = ST_TRACK;
            end
            ST_TRACK: begin
                if (w_win_end) begin
                    if (w_loud) begin
                        w_next = ST_ACQ;
                    end else if (w_quiet && (w_qcnt_inc == QW'(LOCK_WINS))) begin
                        w_next = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                if (w_win_end && w_loud) w_next = ST_ACQ;
            end
            default: w_next = ST_IDLE;
        endcase
        // Dropping the run request overrides every other transition.
        if (!en) w_next = ST_IDLE;
    end

    assign w_chg      = (w_next != r_state);
    assign w_win_clr  = w_chg || !in_window(r_state);
    assign w_trk_gain = (w_next == ST_TRACK) || (w_next == ST_LOCK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_qcnt      <= '0;
            r_hold      <= '0;
            r_frug      <= FRUG_ACQ;
            r_phug      <= PHUG_ACQ;
            r_lf_clr    <= 1'b1;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hold  <= (r_state == ST_CLEAR && !w_chg) ? r_hold + HW'(1) : '0;
            if (w_chg) begin
                r_qcnt <= '0;
            end else if (w_win_end && (r_state == ST_ACQ || r_state == ST_TRACK)) begin
                r_qcnt <= w_quiet ? w_qcnt_inc : '0;
            end
            // Outputs follow the next state so they change on the same edge.
            r_frug      <= w_trk_gain ? FRUG_TRK : FRUG_ACQ;
            r_phug      <= w_trk_gain ? PHUG_TRK : PHUG_ACQ;
            r_lf_clr    <= (w_next == ST_IDLE) || (w_next == ST_CLEAR);
            r_locked    <= (w_next == ST_LOCK);
            r_lock_lost <= (r_state == ST_LOCK) && (w_next == ST_ACQ);
        end
    end

    assign frug      = r_frug;
    assign phug      = r_phug;
    assign lf_clr    = r_lf_clr;
    assign locked    = r_locked;
    assign lock_lost = r_lock_lost;
    assign state     = r_state;

endmodule

// File: tb/tb_cdr_loop_ctrl.sv
// Scoreboard bench for cdr_loop_ctrl: a cycle model pushes expected outputs
// per driven cycle, popped and compared after the clock edge.
module tb_cdr_loop_ctrl;

    localparam int WL  = 16;
    localparam int LT  = 2;
    localparam int UT  = 6;
    localparam int AW  = 2;
    localparam int LW  = 3;
    localparam int HC  = 4;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] fr;
        logic [7:0] ph;
        logic       clr;
        logic       lk;
        logic       ll;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       dn;
    logic [7:0] frug;
    logic [7:0] phug;
    logic       lf_clr;
    logic       locked;
    logic       lock_lost;
    logic [2:0] state;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q_exp[$];

    int m_st, m_cnt, m_net, m_q, m_hold;

    cdr_loop_ctrl #(
        .WIN_LEN    (WL),
        .LOCK_THR   (LT),
        .UNLOCK_THR (UT),
        .ACQ_WINS   (AW),
        .LOCK_WINS  (LW),
        .HOLD_CYC   (HC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up        (up),
        .dn        (dn),
        .frug      (frug),
        .phug      (phug),
        .lf_clr    (lf_clr),
        .locked    (locked),
        .lock_lost (lock_lost),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_vec++;
        if (obs !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, req, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_net = 0; m_q = 0; m_hold = 0;
        q_exp.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_lfclr"}, lf_clr, 1);
        chk({tag, "_frug"}, frug, 8);
        chk({tag, "_phug"}, phug, 16);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_lost"}, lock_lost, 0);
    endtask

    // One clock: drive inputs, predict outputs, push; then pop and compare.
    task automatic step(input bit e, input bit u, input bit d);
        exp_t x;
        int   nst, nn, a;
        bit   we, qt, ld;
        en = e; up = u; dn = d;
        we = (m_st >= 2) && (m_cnt == WL - 1);
        nn = m_net + ((u && !d) ? 1 : 0) - ((d && !u) ? 1 : 0);
        a  = (nn < 0) ? -nn : nn;
        qt = (a <= LT);
        ld = (a > UT);
        nst = m_st;
        case (m_st)
            0: if (e) nst = 1;
            1: if (m_hold == HC - 1) nst = 2;
            2: if (we && qt && (m_q + 1 == AW)) nst = 3;
            3: if (we) begin
                   if (ld) nst = 2;
                   else if (qt && (m_q + 1 == LW)) nst = 4;
               end
            4: if (we && ld) nst = 2;
            default: nst = 0;
        endcase
        if (!e) nst = 0;
        x.ll = (m_st == 4) && (nst == 2);
        if (nst != m_st || m_st < 2 || we) begin
            m_cnt = 0; m_net = 0;
        end else begin
            m_cnt++; m_net = nn;
        end
        if (nst != m_st) m_q = 0;
        else if (we && (m_st == 2 || m_st == 3)) m_q = qt ? m_q + 1 : 0;
        m_hold = (m_st == 1 && nst == 1) ? m_hold + 1 : 0;
        m_st = nst;
        x.st  = 3'(nst);
        x.clr = (nst <= 1);
        x.fr  = (nst >= 3) ? 8'd2 : 8'd8;
        x.ph  = (nst >= 3) ? 8'd4 : 8'd16;
        x.lk  = (nst == 4);
        q_exp.push_back(x);
        @(posedge clk);
        #1;
        x = q_exp.pop_front();
        chk("sb_state", state, x.st);
        chk("sb_frug", frug, x.fr);
        chk("sb_phug", phug, x.ph);
        chk("sb_lfclr", lf_clr, x.clr);
        chk("sb_locked", locked, x.lk);
        chk("sb_lost", lock_lost, x.ll);
    endtask

    task automatic run_const(input int n, input bit u, input bit d);
        for (int i = 0; i < n; i++) step(1'b1, u, d);
    endtask

    task automatic run_alt(input int n);
        for (int i = 0; i < n; i++) step(1'b1, (i % 2) == 0, (i % 2) == 1);
    endtask

    // IDLE -> CLEAR (1 cycle) then the four CLEAR cycles into ACQ.
    task automatic start_up(input bit u, input bit d);
        step(1'b1, u, d);
        chk("clr_entry", state, 1);
        run_const(HC - 1, u, d);
        chk("clr_hold_lfclr", lf_clr, 1);
        step(1'b1, u, d);
        chk("acq_entry", state, 2);
        chk("acq_lfclr", lf_clr, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b0; dn = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk_reset_vals("rst");
        rst = 1'b0;

        // Bring-up with alternating up/dn: ACQ->TRACK in 32, TRACK->LOCK in 48.
        start_up(1'b0, 1'b0);
        chk("acq_gains", {frug, phug}, {8'd8, 8'd16});
        run_alt(31);
        chk("acq_still", state, 2);
        run_alt(1);
        chk("trk_entry", state, 3);
        chk("trk_gains", {frug, phug}, {8'd2, 8'd4});
        run_alt(47);
        chk("trk_still", state, 3);
        run_alt(1);
        chk("lock_entry", state, 4);
        chk("lock_flag", locked, 1);

        // Loud window in LOCK: 10 ups then idle.
        for (int i = 0; i < WL; i++) step(1'b1, i < 10, 1'b0);
        chk("unlock_state", state, 2);
        chk("unlock_pulse", lock_lost, 1);
        chk("unlock_locked", locked, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("unlock_pulse_end", lock_lost, 0);

        // Back to TRACK, then middling windows (+4) keep it in TRACK.
        run_const(31, 1'b0, 1'b0);
        chk("reacq_trk", state, 3);
        for (int w = 0; w < 5; w++)
            for (int i = 0; i < WL; i++) step(1'b1, i < 4, 1'b0);
        chk("mid_trk", state, 3);
        chk("mid_nolock", locked, 0);
        run_const(47, 1'b0, 1'b0);
        chk("mid_trk_still", state, 3);
        run_const(1, 1'b0, 1'b0);
        chk("mid_lock", state, 4);

        // up=dn=1 continuously is quiet; drop en mid-TRACK.
        step(1'b0, 1'b0, 1'b0);
        chk("en_off_lock", state, 0);
        start_up(1'b1, 1'b1);
        run_const(32, 1'b1, 1'b1);
        chk("ud_trk", state, 3);
        run_const(8, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("en_off_trk", state, 0);
        chk("en_off_lfclr", lf_clr, 1);
        chk("en_off_gains", {frug, phug}, {8'd8, 8'd16});

        start_up(1'b1, 1'b1);
        run_const(32, 1'b1, 1'b1);
        chk("ud_trk2", state, 3);
        run_const(48, 1'b1, 1'b1);
        chk("ud_lock", state, 4);

        // Loud window whose closing cycle also drops en: IDLE, no pulse.
        run_const(WL - 1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("coinc_state", state, 0);
        chk("coinc_pulse", lock_lost, 0);

        // Re-lock, then async reset mid-LOCK.
        start_up(1'b0, 1'b0);
        run_const(80, 1'b0, 1'b0);
        chk("relock", state, 4);
        run_const(5, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        model_reset();
        @(posedge clk); #1;
        chk_reset_vals("rst_hold");
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdr_loop_ctrl.md
# cdr_loop_ctrl

Acquisition/tracking controller for the CDR digital loop filter in the PHY receive path. Monitors the phase detector's Up/Dn stream over fixed windows and sequences the filter through clear, acquisition (high gain), tracking (low gain) and locked states. It drives the filter's frequency/phase gain configuration and integrator clear, and reports lock status to the PHY control logic.

## Interface
Parameters:
- WIN_LEN, 256: observation window length in cycles (power of 2, ≥8).
- LOCK_THR, 8: a window is quiet when |net| ≤ LOCK_THR.
- UNLOCK_THR, 32: a window is loud when |net| > UNLOCK_THR (UNLOCK_THR ≥ LOCK_THR).
- ACQ_WINS, 4: consecutive quiet windows needed to leave ACQ.
- LOCK_WINS, 8: consecutive quiet windows needed in TRACK to declare lock.
- HOLD_CYC, 16: cycles lf_clr is held in CLEAR (≥1).
- FRUG_ACQ 8, PHUG_ACQ 16, FRUG_TRK 2, PHUG_TRK 4: gain values, 8 bits each.

Ports:
- clk  in  1  loop clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run request; 0 forces IDLE.
- up  in  1  phase detector "late" pulse.
- dn  in  1  phase detector "early" pulse.
- frug  out  8  frequency-path gain to loop filter.
- phug  out  8  phase-path gain to loop filter.
- lf_clr  out  1  clear/hold loop-filter integrators.
- locked  out  1  lock indication.
- lock_lost  out  1  one-cycle pulse on LOCK→ACQ.
- state  out  3  current state encoding.

## Operation
- States: IDLE=0, CLEAR=1, ACQ=2, TRACK=3, LOCK=4.
- Per cycle: {up,dn}=10 → net+1; 01 → net−1; 00 or 11 → no change.
- Window counter runs 0..WIN_LEN−1 in ACQ/TRACK/LOCK only; zeroed in other states and on every state change. At count WIN_LEN−1, window is evaluated on net including that cycle's up/dn; net and count then restart at 0.
- net: signed, $clog2(WIN_LEN)+2 bits, no saturation needed.
- quiet_cnt: increments on quiet window, clears on any non-quiet window and on state change.
- en=0 in any state → IDLE next cycle (highest priority).
- IDLE: lf_clr=1, ACQ gains, locked=0; en=1 → CLEAR.
- CLEAR: lf_clr=1, ACQ gains; after exactly HOLD_CYC cycles → ACQ.
- ACQ: lf_clr=0, ACQ gains; quiet_cnt reaches ACQ_WINS → TRACK.
- TRACK: TRK gains; quiet_cnt reaches LOCK_WINS → LOCK; loud window → ACQ; window neither quiet nor loud → stay, quiet_cnt cleared.
- LOCK: TRK gains, locked=1; loud window → ACQ with lock_lost pulse; otherwise stay.

## Timing
- All outputs registered; update on the same edge as state.
- Reset values: state=IDLE, lf_clr=1, frug=FRUG_ACQ, phug=PHUG_ACQ, locked=0, lock_lost=0, counters 0.
- en sampled high in IDLE at edge N → CLEAR from N+1; lf_clr falls at edge N+1+HOLD_CYC.
- Window-end evaluation and resulting transition take effect on the edge closing cycle WIN_LEN−1; new gains visible that cycle onward.
- lock_lost high exactly one cycle, coincident with locked falling.
- en=0 coinciding with a window-end transition: IDLE wins, no lock_lost.
- rst mid-operation: immediate return to reset values, no pulse.

## Structure
- Package cdr_ctrl_pkg: state enum (3-bit), default gain constants, gain width localparam.
- Sub-module cdr_win_monitor: window counter, net accumulator, emits win_end, quiet, loud; cleared by controller on state change. Top holds FSM, quiet_cnt, hold counter, output registers.

## Test plan
Use WIN_LEN=16, LOCK_THR=2, UNLOCK_THR=6, ACQ_WINS=2, LOCK_WINS=3, HOLD_CYC=4.
- Reset release, en=1 → state 1, lf_clr=1 for exactly 4 cycles, then state 2 with frug=8, phug=16.
- Alternating up/dn in ACQ → TRACK after 32 cycles (frug=2, phug=4); LOCK after 48 more, locked=1.
- In LOCK, 10 up pulses within one window → at window end state=2, locked=0, lock_lost high 1 cycle, gains 8/16.
- In TRACK, net=+4 per window → stays TRACK indefinitely, locked never asserts; resume net=0 → LOCK after 3 further windows.
- up=dn=1 every cycle → net 0, treated quiet; full ACQ→LOCK sequence completes on same schedule as scenario 2.
- en=0 mid-TRACK → IDLE next cycle, lf_clr=1, gains 8/16; rst pulse mid-LOCK → all outputs at reset values immediately, lock_lost stays 0.
